// File: rtl/lpf_decim_pkg.sv
// Constants shared by the low-pass/decimation path and the upstream biquad.
package lpf_decim_pkg;
  localparam int SAMPLE_W = 32;
  localparam int Q14_FRAC = 14;
endpackage

// File: rtl/sample_fifo.sv
// Circular-buffer output FIFO; head word is presented directly, zero when empty.
module sample_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   cnt;
  logic          do_pop;
  logic          do_push;

  // A push into a full buffer is accepted only when the head leaves on the same edge.
  assign do_pop  = pop && (cnt != {(AW + 1){1'b0}});
  assign do_push = push && (!full || do_pop);
  assign full    = (cnt == CNT_MAX);
  assign level   = cnt;
  assign dout    = (cnt != {(AW + 1){1'b0}}) ? mem[rd_ptr] : {W{1'b0}};

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= {AW{1'b0}};
      wr_ptr <= {AW{1'b0}};
      cnt    <= {(AW + 1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {W{1'b0}};
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/lpf_decim.sv
// Block-average decimator: sums DECIM valid samples, divides by shift (floor),
// and queues each result in an output FIFO with a sticky overflow flag.
module lpf_decim
  import lpf_decim_pkg::*;
#(
  parameter int DECIM = 4,
  parameter int DEPTH = 4
) (
  input  logic                       insclk,
  input  logic                       rst,
  input  logic [SAMPLE_W-1:0]        x,
  input  logic                       x_valid,
  output logic [SAMPLE_W-1:0]        y,
  output logic                       y_valid,
  input  logic                       y_ready,
  output logic                       ovf,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int SH = $clog2(DECIM);
  localparam int AW = SAMPLE_W + SH;
  localparam logic [SH-1:0] PH_ZERO = {SH{1'b0}};
  localparam logic [SH-1:0] PH_ONE  = SH'(1);
  localparam logic [SH-1:0] PH_LAST = SH'(DECIM - 1);

  logic [SH-1:0]         phase;
  logic signed [AW-1:0]  acc;
  logic signed [AW-1:0]  x_ext;
  logic signed [AW-1:0]  sum;
  logic signed [AW-1:0]  shifted;
  logic [SAMPLE_W-1:0]   result;
  logic                  last;
  logic                  push;
  logic                  pop;
  logic                  full;

  assign x_ext   = {{SH{x[SAMPLE_W-1]}}, x};
  assign sum     = acc + x_ext;
  assign shifted = sum >>> SH;
  assign result  = shifted[SAMPLE_W-1:0];
  assign last    = (phase == PH_LAST);
  assign push    = x_valid && last;
  assign pop     = y_ready && y_valid;
  assign y_valid = (level != {($clog2(DEPTH) + 1){1'b0}});

  // Phase counter, accumulator and sticky overflow; idle cycles freeze the group.
  always_ff @(posedge insclk or posedge rst) begin
    if (rst) begin
      phase <= PH_ZERO;
      acc   <= {AW{1'b0}};
      ovf   <= 1'b0;
    end else begin
      if (x_valid) begin
        phase <= last ? PH_ZERO : (phase + PH_ONE);
        acc   <= (phase == PH_ZERO) ? x_ext : sum;
      end
      if (push && full && !pop) begin
        ovf <= 1'b1;
      end
    end
  end

  sample_fifo #(
    .W     (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (insclk),
    .rst   (rst),
    .push  (push),
    .din   (result),
    .pop   (pop),
    .dout  (y),
    .full  (full),
    .level (level)
  );
endmodule

// File: doc/lpf_decim.md
LPF_DECIM -- requirements
Module: lpf_decim

Interface
REQ-001 SHALL have parameter DECIM, default 4: decimation ratio; power of two, 2..16.
REQ-002 SHALL have parameter DEPTH, default 4: output FIFO depth in words; power of two, 2..16.
REQ-003 SHALL have port insclk  input  1: single sample clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port x  input  32: signed filtered sample from the biquad low-pass output.
REQ-006 SHALL have port x_valid  input  1: x holds a new sample this cycle.
REQ-007 SHALL have port y  output  32: signed decimated sample at the FIFO head.
REQ-008 SHALL have port y_valid  output  1: y holds a valid word.
REQ-009 SHALL have port y_ready  input  1: consumer accepts y this cycle.
REQ-010 SHALL have port ovf  output  1: sticky flag; a result was dropped because the FIFO was full.
REQ-011 SHALL have port level  output  $clog2(DEPTH)+1: number of words held in the FIFO.

Function
REQ-012 SHALL keep a phase counter 0..DECIM-1 that advances only on cycles with x_valid=1, wrapping DECIM-1 -> 0.
REQ-013 SHALL keep a signed accumulator 32+$clog2(DECIM) bits wide, with sign extension of x; it never overflows.
REQ-014 On x_valid with phase=0, the accumulator SHALL load x; otherwise it SHALL add x.
REQ-015 On x_valid with phase=DECIM-1, SHALL form result = (acc + x) >>> $clog2(DECIM), arithmetic shift truncating toward minus infinity, lower 32 bits, and offer it as a push to the FIFO.
REQ-016 Ordering SHALL be: the pushed word is visible at y with y_valid=1 on the cycle after the posedge that sampled the last x of the group, when the FIFO was empty.
REQ-017 On a posedge with y_valid=1 and y_ready=1, the FIFO SHALL pop; y_ready while y_valid=0 SHALL be ignored.
REQ-018 y SHALL hold stable while y_valid=1 and y_ready=0.
REQ-019 Push when full without a same-cycle pop SHALL drop the result, set ovf, and leave FIFO contents unchanged.
REQ-020 Push and pop on the same edge SHALL both take effect; level is unchanged, including when full.
REQ-021 Push and pop on the same edge with the FIFO empty is impossible by definition, since y_valid=0.
REQ-022 The FIFO SHALL be a circular buffer with read and write pointers wrapping at DEPTH; level SHALL equal pushes minus pops.
REQ-023 y_valid SHALL equal (level != 0); y SHALL be 0 when the FIFO is empty.
REQ-024 ovf SHALL clear only on rst.
REQ-025 x_valid=0 SHALL freeze the phase counter and the accumulator.

Reset
REQ-026 Asserting rst SHALL force, without waiting for a clock: phase=0, acc=0, FIFO empty (pointers 0, level=0), y=0, y_valid=0, ovf=0.
REQ-027 rst asserted mid-group SHALL discard the partial accumulation; the first x_valid after release SHALL start a new group at phase 0.
REQ-028 Samples presented while rst=1 SHALL be ignored.

Structure
REQ-029 A shared package SHALL hold the sample width constant (32) and the Q14 fractional-bit constant shared with the biquad.
REQ-030 The FIFO SHALL be one sub-module, sample_fifo, parameterised by width and DEPTH; the accumulator and phase logic SHALL stay in lpf_decim.

Verification
REQ-031 Scenario 1, basic decimation: DECIM=4, y_ready=1, x_valid=1, x = 10,20,30,40 -> y=25 with y_valid for exactly 1 cycle, one cycle after the 40 edge.
REQ-032 Scenario 2, negative rounding: x = -1,-1,-1,-2 -> y=-2 (floor of -5/4).
REQ-033 Scenario 3, overflow: y_ready=0, 5 full groups of x=1 -> level=4, ovf=1, and the FIFO still holds four words of 1.
REQ-034 Scenario 4, full with simultaneous pop and push: pulse y_ready=1 on the push edge -> level stays 4, ovf unchanged; the last result appears in order after three more pops.
REQ-035 Scenario 5, gaps and reset: x_valid toggled 1,0,1,0 with x=8,99,8 (99 invalid) -> the group sum ignores 99; then assert rst after 2 samples -> level=0, y_valid=0 immediately, and the next group of 4,4,4,4 gives y=4.
REQ-036 Scenario 6, corner values: x = 0x7FFFFFFF for a full group -> y=0x7FFFFFFF; x = 0x80000000 for a full group -> y=0x80000000.
